// File: rtl/lookup_rule_loader.sv
// lookup_rule_loader
//   Configuration-side writer for a parser/deparser stage's type-lookup rule
//   table. Consumes a framed 32-bit config stream, keeps only packets whose
//   header stage field matches STAGE_ID, assembles one rule in a shadow
//   register (LSB word first) and commits it with a one-cycle one-hot strobe.
//   CLEAR_ALL drives an all-ones strobe with zero rule data.
//
//   Ports:
//     i_clk, i_rst       clock, asynchronous active-high reset
//     i_cfg_valid/data/last, o_cfg_ready   config stream (valid/ready, framed)
//     o_rule_wren        RULE_NUM-wide write strobe (one-hot or all-ones)
//     o_type_rule        rule data, meaningful while o_rule_wren != 0
//     o_busy             FSM outside IDLE
//     o_err_cnt          saturating count of malformed packets for this stage
//     o_ack_valid, o_ack_status   end-of-packet acknowledge, present only when
//                        the LOADER_ACK_EN macro is defined
//                        (0 OK, 1 bad index, 2 length error, 3 bad opcode)
//
//   Header word: [31:24] opcode (0x01 WRITE, 0x02 CLEAR_ALL), [23:16] stage,
//   [15:8] reserved, [7:0] index.

package lookup_rule_pkg;
  typedef logic [79:0] type_rule_t;
endpackage

module lookup_rule_loader
  import lookup_rule_pkg::*;
#(
  parameter int         RULE_NUM   = 8,
  parameter int         RULE_WIDTH = $bits(type_rule_t),
  parameter logic [7:0] STAGE_ID   = 8'd0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  input  logic [31:0]         i_cfg_data,
  input  logic                i_cfg_last,
  output logic                o_cfg_ready,
  output logic [RULE_NUM-1:0] o_rule_wren,
  output type_rule_t          o_type_rule,
  output logic                o_busy,
  output logic [15:0]         o_err_cnt
`ifdef LOADER_ACK_EN
  ,
  output logic                o_ack_valid,
  output logic [1:0]          o_ack_status
`endif
);

  localparam int WORDS = (RULE_WIDTH + 31) / 32;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [8:0] RULE_NUM_W = 9'(RULE_NUM);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_CLEAR = 8'h02;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_BADIDX = 2'd1;
  localparam logic [1:0] ST_LEN    = 2'd2;
  localparam logic [1:0] ST_BADOP  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMMIT, S_CLEAR, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            idx_q;
  logic [RULE_WIDTH-1:0] shadow_q;
  logic                  pend_own_q, pend_own_d;
  logic [1:0]            pend_code_q, pend_code_d;

  logic       accept;
  logic       load_hdr, load_word, clear_shadow;
  logic       end_own;
  logic [1:0] end_code;
  logic       hdr_err;
  logic [1:0] hdr_code;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign o_cfg_ready = (state_q != S_COMMIT) && (state_q != S_CLEAR);
  assign accept      = i_cfg_valid && o_cfg_ready;
  assign o_busy      = (state_q != S_IDLE);
  assign o_type_rule = type_rule_t'(shadow_q);

  always_comb begin
    o_rule_wren = '0;
    if (state_q == S_CLEAR) begin
      o_rule_wren = '1;
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < RULE_NUM; i++) o_rule_wren[i] = (idx_q == 8'(i));
    end
  end

  // Next-state and per-beat control. A packet that ends on a beat it was
  // addressed by raises end_own with its status; errors found at the header
  // or mid-payload are parked in pend_* until DRAIN sees the last beat.
  always_comb begin
    state_d      = state_q;
    pend_own_d   = pend_own_q;
    pend_code_d  = pend_code_q;
    load_hdr     = 1'b0;
    load_word    = 1'b0;
    clear_shadow = 1'b0;
    end_own      = 1'b0;
    end_code     = ST_OK;
    hdr_err      = 1'b0;
    hdr_code     = ST_OK;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (i_cfg_data[23:16] != STAGE_ID) begin
            pend_own_d = 1'b0;
            state_d    = i_cfg_last ? S_IDLE : S_DRAIN;
          end else if (i_cfg_data[31:24] == OP_WRITE) begin
            if ({1'b0, i_cfg_data[7:0]} >= RULE_NUM_W) begin
              hdr_err  = 1'b1;
              hdr_code = ST_BADIDX;
            end else if (i_cfg_last) begin
              hdr_err  = 1'b1;
              hdr_code = ST_LEN;
            end else begin
              load_hdr = 1'b1;
              state_d  = S_LOAD;
            end
          end else if (i_cfg_data[31:24] == OP_CLEAR) begin
            if (i_cfg_last) begin
              clear_shadow = 1'b1;
              end_own      = 1'b1;
              end_code     = ST_OK;
              state_d      = S_CLEAR;
            end else begin
              hdr_err  = 1'b1;
              hdr_code = ST_LEN;
            end
          end else begin
            hdr_err  = 1'b1;
            hdr_code = ST_BADOP;
          end
          if (hdr_err) begin
            if (i_cfg_last) begin
              end_own  = 1'b1;
              end_code = hdr_code;
              state_d  = S_IDLE;
            end else begin
              pend_own_d  = 1'b1;
              pend_code_d = hdr_code;
              state_d     = S_DRAIN;
            end
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          load_word = 1'b1;
          if (i_cfg_last) begin
            end_own  = 1'b1;
            end_code = (cnt_q == LAST_WORD) ? ST_OK : ST_LEN;
            state_d  = (cnt_q == LAST_WORD) ? S_COMMIT : S_IDLE;
          end else if (cnt_q == LAST_WORD) begin
            pend_own_d  = 1'b1;
            pend_code_d = ST_LEN;
            state_d     = S_DRAIN;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_CLEAR:  state_d = S_IDLE;
      S_DRAIN: begin
        if (accept && i_cfg_last) begin
          end_own  = pend_own_q;
          end_code = pend_code_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_own_q  <= 1'b0;
      pend_code_q <= ST_OK;
      o_err_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      pend_own_q  <= pend_own_d;
      pend_code_q <= pend_code_d;
      if (load_hdr) begin
        idx_q <= i_cfg_data[7:0];
        cnt_q <= '0;
      end else if (load_word) begin
        cnt_q <= CNT_W'(cnt_q + 1'b1);
      end
      if (end_own && (end_code != ST_OK)) o_err_cnt <= sat_inc16(o_err_cnt);
    end
  end

  // Shadow rule: word k lands in bits [32k+31:32k]; bits past RULE_WIDTH in
  // the final word have no home and are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_q <= '0;
    end else if (clear_shadow) begin
      shadow_q <= '0;
    end else if (load_word) begin
      for (int b = 0; b < RULE_WIDTH; b++) begin
        if (CNT_W'(b / 32) == cnt_q) shadow_q[b] <= i_cfg_data[b % 32];
      end
    end
  end

`ifdef LOADER_ACK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack_valid  <= 1'b0;
      o_ack_status <= 2'd0;
    end else begin
      o_ack_valid  <= end_own;
      o_ack_status <= end_own ? end_code : 2'd0;
    end
  end
`endif

endmodule

// File: tb/tb_lookup_rule_loader.sv
module tb_lookup_rule_loader;
  import lookup_rule_pkg::*;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic [31:0]      cfg_data;
  logic             cfg_last;
  logic             cfg_ready;
  logic [7:0]       rule_wren;
  type_rule_t       type_rule;
  logic             busy;
  logic [15:0]      err_cnt;
`ifdef LOADER_ACK_EN
  logic             ack_valid;
  logic [1:0]       ack_status;
`endif

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int strobe_base;

  lookup_rule_loader #(.RULE_NUM(8), .STAGE_ID(8'd0)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_valid (cfg_valid),
    .i_cfg_data  (cfg_data),
    .i_cfg_last  (cfg_last),
    .o_cfg_ready (cfg_ready),
    .o_rule_wren (rule_wren),
    .o_type_rule (type_rule),
    .o_busy      (busy),
    .o_err_cnt   (err_cnt)
`ifdef LOADER_ACK_EN
    ,
    .o_ack_valid (ack_valid),
    .o_ack_status(ack_status)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rule_wren != 8'h00) strobes++;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns #1 after the
  // accepting edge. A beat that is never accepted counts as a failure.
  task automatic beat(input logic [31:0] d, input logic l);
    logic got;
    got = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    check("beat_accepted", {95'd0, got}, 96'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    rst       = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_wren", 96'(rule_wren), 96'h0);
    check("rst_rule", 96'(type_rule), 96'h0);
    check("rst_err",  96'(err_cnt), 96'h0);
    check("rst_busy", 96'(busy), 96'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    check("rst_ready", 96'(cfg_ready), 96'h1);

    // Write index 5
    strobe_base = strobes;
    beat(32'h01000005, 1'b0);
    check("wr_busy_load", 96'(busy), 96'h1);
    beat(32'h11111111, 1'b0);
    beat(32'h22222222, 1'b0);
    beat(32'h0000BEEF, 1'b1);
    check("wr_wren",  96'(rule_wren), 96'h20);
    check("wr_rule",  96'(type_rule), 96'h0000BEEF_22222222_11111111);
    check("wr_ready_low", 96'(cfg_ready), 96'h0);
`ifdef LOADER_ACK_EN
    check("wr_ack_v", 96'(ack_valid), 96'h1);
    check("wr_ack_s", 96'(ack_status), 96'h0);
`endif
    tick();
    check("wr_wren_off", 96'(rule_wren), 96'h0);
    check("wr_ready_back", 96'(cfg_ready), 96'h1);
    check("wr_rule_hold", 96'(type_rule), 96'h0000BEEF_22222222_11111111);
    check("wr_strobes", 96'(strobes - strobe_base), 96'd1);

    // Stage filter: stage 3 is not ours
    strobe_base = strobes;
    beat(32'h01030005, 1'b0);
    beat(32'h33333333, 1'b0);
    beat(32'h44444444, 1'b0);
    beat(32'h00005555, 1'b1);
    tick();
    check("flt_strobes", 96'(strobes - strobe_base), 96'd0);
    check("flt_err", 96'(err_cnt), 96'd0);
    check("flt_busy", 96'(busy), 96'h0);
    check("flt_rule_hold", 96'(type_rule), 96'h0000BEEF_22222222_11111111);

    // Short packet
    strobe_base = strobes;
    beat(32'h01000001, 1'b0);
    beat(32'h12345678, 1'b1);
    check("short_err", 96'(err_cnt), 96'd1);
`ifdef LOADER_ACK_EN
    check("short_ack_v", 96'(ack_valid), 96'h1);
    check("short_ack_s", 96'(ack_status), 96'h2);
`endif
    tick();
    check("short_strobes", 96'(strobes - strobe_base), 96'd0);
    check("short_busy", 96'(busy), 96'h0);

    // Bad index 9 with RULE_NUM=8
    strobe_base = strobes;
    beat(32'h01000009, 1'b0);
    check("bidx_drain_busy", 96'(busy), 96'h1);
    beat(32'hAAAA0001, 1'b0);
    beat(32'hAAAA0002, 1'b0);
    beat(32'hAAAA0003, 1'b1);
    check("bidx_err", 96'(err_cnt), 96'd2);
`ifdef LOADER_ACK_EN
    check("bidx_ack_s", 96'(ack_status), 96'h1);
`endif
    tick();
    check("bidx_strobes", 96'(strobes - strobe_base), 96'd0);

    // CLEAR_ALL
    beat(32'h02000000, 1'b1);
    check("clr_wren",  96'(rule_wren), 96'hFF);
    check("clr_rule",  96'(type_rule), 96'h0);
    check("clr_ready", 96'(cfg_ready), 96'h0);
    tick();
    check("clr_wren_off", 96'(rule_wren), 96'h0);
    check("clr_ready_back", 96'(cfg_ready), 96'h1);
    check("clr_err", 96'(err_cnt), 96'd2);

    // Reset after second payload word, then clean write to index 2
    strobe_base = strobes;
    beat(32'h01000002, 1'b0);
    beat(32'h55555555, 1'b0);
    beat(32'h66666666, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 96'(busy), 96'h0);
    check("mid_rst_err",  96'(err_cnt), 96'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    check("mid_rst_wren", 96'(rule_wren), 96'h0);
    beat(32'h01000002, 1'b0);
    beat(32'hAAAAAAAA, 1'b0);
    repeat (3) tick();
    check("stall_busy", 96'(busy), 96'h1);
    beat(32'hBBBBBBBB, 1'b0);
    beat(32'h0000CCCC, 1'b1);
    check("rec_wren", 96'(rule_wren), 96'h04);
    check("rec_rule", 96'(type_rule), 96'h0000CCCC_BBBBBBBB_AAAAAAAA);
    tick();
    check("rec_strobes", 96'(strobes - strobe_base), 96'd1);

    // Unknown opcode ending on its header
    beat(32'h07000000, 1'b1);
    check("bop_err", 96'(err_cnt), 96'd1);
`ifdef LOADER_ACK_EN
    check("bop_ack_s", 96'(ack_status), 96'h3);
`endif
    tick();
    check("bop_wren", 96'(rule_wren), 96'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lookup_rule_loader.md
# lookup_rule_loader

Configuration-side writer for the parser's per-stage type-lookup rule table. Accepts a framed 32-bit configuration stream (valid/ready, last), filters it by stage ID, assembles one packed `type_rule_t` in a shadow register, and commits it with a one-cycle one-hot `rule_wren` strobe. It sits between the control-plane config bus and each parser or deparser stage's type-lookup block, driving that block's rule-write port.

## Interface
- `RULE_NUM`, 8: number of rule entries in the target table; ≤ 256.
- `RULE_WIDTH`, `$bits(type_rule_t)`: packed rule width.
- `STAGE_ID`, 0: 8-bit stage address this instance responds to.
- Derived `WORDS` = ceil(RULE_WIDTH/32): payload words per rule.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_cfg_valid`  in  1  config word valid.
- `i_cfg_data`  in  32  config word.
- `i_cfg_last`  in  1  last word of packet.
- `o_cfg_ready`  out  1  loader accepts word.
- `o_rule_wren`  out  RULE_NUM  one-hot (or all-ones) write strobe.
- `o_type_rule`  out  type_rule_t  rule data, valid whenever `o_rule_wren` ≠ 0.
- `o_busy`  out  1  high when the FSM is outside IDLE.
- `o_err_cnt`  out  16  saturating count of malformed packets addressed to this stage.

## Operation
- Beat accepted when `i_cfg_valid & o_cfg_ready`.
- Header word (first beat of each packet) fields:
  - [31:24] opcode: 0x01 = WRITE, 0x02 = CLEAR_ALL.
  - [23:16] stage.
  - [7:0] index.
  - [15:8] reserved, ignored.
- FSM states: IDLE, LOAD, COMMIT, CLEAR, DRAIN.
- IDLE: on header:
  - stage ≠ STAGE_ID: go to DRAIN, or stay IDLE if last. No error.
  - WRITE, index < RULE_NUM, not last: go to LOAD, word counter = 0.
  - WRITE with index ≥ RULE_NUM: error. Go to DRAIN, or IDLE if last.
  - WRITE with last on header: length error, go to IDLE.
  - CLEAR_ALL with last: go to CLEAR.
  - CLEAR_ALL without last: error, go to DRAIN.
  - Any other opcode: error, go to DRAIN or IDLE.
- LOAD: payload word k fills shadow bits [32k+31:32k], LSB word first. Bits beyond RULE_WIDTH in the final word are ignored.
  - last on word WORDS-1: go to COMMIT.
  - last earlier: length error, shadow discarded, go to IDLE, no write.
  - word WORDS-1 without last: length error, go to DRAIN, no write.
- COMMIT: `o_rule_wren` = 1<<index for exactly one cycle, `o_type_rule` = shadow. Then go to IDLE.
- CLEAR: `o_rule_wren` = all ones, `o_type_rule` = 0 for one cycle. Then go to IDLE.
- DRAIN: accept and discard beats until last, then go to IDLE.
- `o_cfg_ready` = 1 in IDLE, LOAD, DRAIN; 0 in COMMIT and CLEAR.
- Error counter: +1 per malformed packet for this stage; saturates at 0xFFFF.

## Timing
- Reset values:
  - `o_rule_wren` = 0, `o_type_rule` = 0, `o_err_cnt` = 0, `o_busy` = 0.
  - `o_cfg_ready` = 1 after reset deasserts.
  - FSM in IDLE.
- Write latency: if the last payload beat is accepted in cycle N, `o_rule_wren` pulses in N+1, `o_cfg_ready` is 0 in N+1 and 1 again in N+2.
- CLEAR: header with last accepted in N, all-ones strobe in N+1.
- Minimum packet-to-packet spacing: one bubble cycle after a commit.
- `o_type_rule` is held stable outside LOAD, so a downstream stage sees a steady value during the strobe.
- `i_cfg_valid` low mid-packet stalls with state and counter held; there is no timeout.
- Reset mid-packet: the partial rule is dropped, no strobe is issued, and the remaining beats of that packet are treated as new headers by the sender's responsibility.

## Configuration
- `LOADER_ACK_EN` defined: adds output ports `o_ack_valid` (1) and `o_ack_status` (2).
  - One-cycle pulse at the end of every packet addressed to this stage, in the cycle after its last beat is accepted. For a WRITE this is the same cycle as the strobe.
  - Status codes: 0 = OK, 1 = bad index, 2 = length error, 3 = bad opcode.
  - Both ports reset to 0.
- Undefined: these ports are absent and only `o_err_cnt` reports errors.

## Test plan
- Write, RULE_WIDTH=80 (WORDS=3):
  - Stimulus: header 0x01000005 to STAGE_ID=0, then 0x11111111, 0x22222222, 0x0000BEEF with last.
  - Required: `o_rule_wren` = 0x20 for one cycle; `o_type_rule` = 0xBEEF_22222222_11111111; ack status 0.
- Stage filter: same packet with stage field 0x03.
  - Required: no strobe, `o_err_cnt` unchanged, all beats accepted.
- Short packet: header plus one payload word with last.
  - Required: no strobe, `o_err_cnt` = 1, ack status 2.
- Bad index: header 0x01000009 with RULE_NUM=8, then 3 words.
  - Required: words drained, no strobe, ack status 1.
- CLEAR_ALL: header 0x02000000 with last.
  - Required: `o_rule_wren` = 0xFF and `o_type_rule` = 0 for one cycle; `o_cfg_ready` low that cycle.
- Reset after the second payload word, then a clean write to index 2.
  - Required: no strobe during recovery; the later packet gives `o_rule_wren` = 0x04.
